// File: rtl/conv_stream_driver_if.sv
// Bus bundle between the conv stream driver and its environment.
//   src_rd_*  : source memory read port (ifmap + weights), data 1 cycle after the strobe
//   tx_*      : valid/ready stream into the conv core din port, tx_phase marks weight words
//   rx_*      : valid/ready stream from the conv core dout port
//   res_wr_*  : result memory write port
// master = driver side, slave = memories / conv core side.
interface conv_stream_driver_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 12
);
  logic          src_rd_en;
  logic [AW-1:0] src_rd_addr;
  logic [DW-1:0] src_rd_data;

  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] tx_data;
  logic          tx_phase;

  logic          rx_valid;
  logic          rx_ready;
  logic [DW-1:0] rx_data;

  logic          res_wr_en;
  logic [AW-1:0] res_wr_addr;
  logic [DW-1:0] res_wr_data;

  modport master (
    output src_rd_en, src_rd_addr,
    input  src_rd_data,
    output tx_valid, tx_data, tx_phase,
    input  tx_ready,
    input  rx_valid, rx_data,
    output rx_ready,
    output res_wr_en, res_wr_addr, res_wr_data
  );

  modport slave (
    input  src_rd_en, src_rd_addr,
    output src_rd_data,
    input  tx_valid, tx_data, tx_phase,
    output tx_ready,
    output rx_valid, rx_data,
    input  rx_ready,
    input  res_wr_en, res_wr_addr, res_wr_data
  );
endinterface

// File: rtl/conv_stream_driver.sv
// Conv stream driver: on start, streams N_IF ifmap words then N_W weight words from the
// source memory into the conv core, then collects N_OF result words into result memory.
// Ports:
//   clk   : sole clock, rising edge
//   rst   : synchronous active-high reset
//   start : job request, only honoured in IDLE
//   busy  : high while sending or receiving
//   done  : one-cycle pulse at job end
//   bus   : conv_stream_driver_if master (source read, tx stream, rx stream, result write)
module conv_stream_driver #(
  parameter int unsigned N_IF = 1728,
  parameter int unsigned N_W  = 1296,
  parameter int unsigned N_OF = 1200,
  parameter int unsigned DW   = 16,
  parameter int unsigned AW   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  conv_stream_driver_if.master bus
);

  localparam logic [AW-1:0] NumTx   = AW'(N_IF + N_W);
  localparam logic [AW-1:0] TxLast  = AW'(N_IF + N_W - 1);
  localparam logic [AW-1:0] WgtBase = AW'(N_IF);
  localparam logic [AW-1:0] RxLast  = AW'(N_OF - 1);

  typedef enum logic [1:0] {StIdle, StSend, StRecv, StFin} state_e;

  state_e        state_q;
  logic [AW-1:0] rd_cnt_q;    // reads issued
  logic [AW-1:0] tx_cnt_q;    // tx handshakes
  logic [AW-1:0] rx_cnt_q;    // rx handshakes
  logic          inflight_q;  // read issued last cycle, data on src_rd_data now
  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    fifo_cnt_q;

  logic          rd_en;
  logic          tx_valid_int;
  logic [DW-1:0] tx_data_int;
  logic          tx_hs;
  logic          rx_hs;
  logic          push;
  logic          pop;

  always_comb begin
    rd_en = (state_q == StSend) && (rd_cnt_q < NumTx) &&
            (({1'b0, fifo_cnt_q} + {2'b0, inflight_q}) < 3'd2);
    // Returning data is visible the cycle it arrives, so an empty FIFO does not cost a cycle.
    tx_valid_int = (state_q == StSend) && ((fifo_cnt_q != 2'd0) || inflight_q);
    tx_data_int  = (fifo_cnt_q != 2'd0) ? mem_q[rd_ptr_q] : bus.src_rd_data;
    tx_hs        = tx_valid_int && bus.tx_ready;
    rx_hs        = (state_q == StRecv) && bus.rx_valid;
    // Arriving word is stored unless it went straight out through the bypass.
    push         = inflight_q && !(tx_hs && (fifo_cnt_q == 2'd0));
    pop          = tx_hs && (fifo_cnt_q != 2'd0);
  end

  // Outputs are forced to their idle values while rst is high.
  always_comb begin
    busy             = !rst && ((state_q == StSend) || (state_q == StRecv));
    done             = !rst && (state_q == StFin);
    bus.src_rd_en    = !rst && rd_en;
    bus.src_rd_addr  = bus.src_rd_en ? rd_cnt_q : '0;
    bus.tx_valid     = !rst && tx_valid_int;
    bus.tx_data      = bus.tx_valid ? tx_data_int : '0;
    bus.tx_phase     = bus.tx_valid && (tx_cnt_q >= WgtBase);
    bus.rx_ready     = !rst && (state_q == StRecv);
    bus.res_wr_en    = !rst && rx_hs;
    bus.res_wr_addr  = bus.res_wr_en ? rx_cnt_q : '0;
    bus.res_wr_data  = bus.res_wr_en ? bus.rx_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rd_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      inflight_q <= rd_en;
      if (rd_en) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (push) begin
        mem_q[wr_ptr_q] <= bus.src_rd_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StSend;
            rd_cnt_q <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
          end
        end
        StSend: begin
          if (tx_hs) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
            if (tx_cnt_q == TxLast) state_q <= StRecv;
          end
        end
        StRecv: begin
          if (rx_hs) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
            if (rx_cnt_q == RxLast) state_q <= StFin;
          end
        end
        StFin: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_driver.sv
module tb_conv_stream_driver;
  localparam int unsigned N_IF  = 1728;
  localparam int unsigned N_W   = 1296;
  localparam int unsigned N_OF  = 1200;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 12;
  localparam int unsigned TOTAL = N_IF + N_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  conv_stream_driver_if #(.DW(DW), .AW(AW)) bus ();

  conv_stream_driver #(
    .N_IF(N_IF), .N_W(N_W), .N_OF(N_OF), .DW(DW), .AW(AW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .busy (busy),
    .done (done),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Source memory: word k holds k; anything not requested reads as garbage.
  always @(posedge clk)
    bus.src_rd_data <= bus.src_rd_en ? DW'(bus.src_rd_addr) : 16'hDEAD;

  // Conv core stand-in: result word n is 0xA000+n.
  int rx_sent = 0;
  assign bus.rx_data = 16'hA000 + rx_sent[15:0];

  int ready_mode = 0;  // 0: tx_ready always 1, 1: random
  int rx_mode = 0;     // 0: rx_valid random, 1: always 1

  initial begin
    logic hs;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    forever begin
      @(negedge clk);
      hs = bus.rx_valid && bus.rx_ready;
      @(posedge clk);
      #1;
      if (hs) rx_sent++;
      bus.tx_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.rx_valid = (rx_mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Behavioural model: job phase 0 idle, 1 send, 2 recv, 3 fin; expected word indices.
  int phase = 0;
  int exp_rd = 0, exp_tx = 0, exp_rx = 0;
  int cyc = 0, start_cyc = 0, done_cnt = 0;
  int phase_rise_word = -1;
  bit first_tx_seen = 0, prev_stall = 0, rst_prev = 0;
  int res_mem [N_OF];

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_done"},     32'(done), 0);
    chk({tag, "_rd_en"},    32'(bus.src_rd_en), 0);
    chk({tag, "_rd_addr"},  32'(bus.src_rd_addr), 0);
    chk({tag, "_tx_valid"}, 32'(bus.tx_valid), 0);
    chk({tag, "_tx_data"},  32'(bus.tx_data), 0);
    chk({tag, "_tx_phase"}, 32'(bus.tx_phase), 0);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 0);
    chk({tag, "_wr_en"},    32'(bus.res_wr_en), 0);
    chk({tag, "_wr_addr"},  32'(bus.res_wr_addr), 0);
    chk({tag, "_wr_data"},  32'(bus.res_wr_data), 0);
  endtask

  always @(negedge clk) begin
    int nxt;
    cyc++;
    if (rst) begin
      check_zero("in_reset");
      phase = 0;
      prev_stall = 0;
      rst_prev = 1;
    end else begin
      if (rst_prev) check_zero("after_reset");
      rst_prev = 0;
      nxt = phase;
      chk("busy", 32'(busy), 32'(phase == 1 || phase == 2));
      chk("done", 32'(done), 32'(phase == 3));
      chk("rx_ready", 32'(bus.rx_ready), 32'(phase == 2));
      if (done) done_cnt++;
      if (phase != 1) begin
        chk("tx_valid_outside_send", 32'(bus.tx_valid), 0);
        chk("rd_en_outside_send", 32'(bus.src_rd_en), 0);
        prev_stall = 0;
      end
      if (phase != 2) chk("wr_en_outside_recv", 32'(bus.res_wr_en), 0);
      if (phase == 1) begin
        if (bus.src_rd_en) begin
          chk("rd_addr", 32'(bus.src_rd_addr), 32'(exp_rd));
          chk("rd_window", 32'((exp_rd - exp_tx) < 2), 1);
          chk("rd_count", 32'(exp_rd < TOTAL), 1);
          if (exp_rd == 0) chk("rd_latency", 32'(cyc - start_cyc), 1);
          exp_rd++;
        end
        if (prev_stall) chk("tx_hold_valid", 32'(bus.tx_valid), 1);
        if (ready_mode == 0 && cyc >= start_cyc + 2)
          chk("tx_stream_full_rate", 32'(bus.tx_valid), 1);
        if (bus.tx_valid) begin
          if (!first_tx_seen) chk("tx_latency", 32'(cyc - start_cyc), 2);
          first_tx_seen = 1;
          chk("tx_data", 32'(bus.tx_data), 32'(exp_tx));
          chk("tx_phase", 32'(bus.tx_phase), 32'(exp_tx >= N_IF));
          if (bus.tx_phase && phase_rise_word < 0) phase_rise_word = int'(bus.tx_data);
          if (bus.tx_ready) begin
            exp_tx++;
            if (exp_tx == TOTAL) nxt = 2;
          end
        end
        prev_stall = bus.tx_valid && !bus.tx_ready;
      end
      if (phase == 2) begin
        chk("wr_en", 32'(bus.res_wr_en), 32'(bus.rx_valid));
        if (bus.rx_valid) begin
          chk("wr_addr", 32'(bus.res_wr_addr), 32'(exp_rx));
          chk("wr_data", 32'(bus.res_wr_data), 32'(16'hA000 + exp_rx));
          if (bus.res_wr_addr < AW'(N_OF)) res_mem[bus.res_wr_addr] = int'(bus.res_wr_data);
          exp_rx++;
          if (exp_rx == N_OF) nxt = 3;
        end
      end
      if (phase == 3) nxt = 0;
      if (phase == 0 && start) begin
        nxt = 1;
        start_cyc = cyc;
        exp_rd = 0;
        exp_tx = 0;
        exp_rx = 0;
        first_tx_seen = 0;
        phase_rise_word = -1;
      end
      phase = nxt;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_phase(input int p, input int limit, input string name);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (phase == p) break;
    end
    if (i == limit) chk({name, "_timeout"}, 0, 1);
  endtask

  // One full job; with noise, start is also pulsed during SEND, RECV and FIN.
  task automatic run_job(input bit noise, input string tag);
    int d0, i, bad;
    foreach (res_mem[k]) res_mem[k] = -1;
    rx_sent = 0;
    d0 = done_cnt;
    pulse_start();
    if (noise) begin
      repeat (100) @(posedge clk);
      pulse_start();
      wait_phase(2, 20000, {tag, "_recv"});
      repeat (50) @(posedge clk);
      pulse_start();
      wait_phase(3, 20000, {tag, "_fin"});
      pulse_start();
    end
    for (i = 0; i < 30000; i++) begin
      @(negedge clk); #1;
      if (done_cnt > d0) break;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt > d0), 1);
    repeat (4) @(posedge clk);
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 1);
    chk({tag, "_tx_words"}, 32'(exp_tx), 3024);
    chk({tag, "_rx_words"}, 32'(exp_rx), 1200);
    bad = 0;
    foreach (res_mem[k]) if (res_mem[k] != 32'hA000 + k) bad++;
    chk({tag, "_res_mem_bad"}, 32'(bad), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Full-rate tx, random rx_valid.
    ready_mode = 0; rx_mode = 0;
    run_job(1'b0, "jobA");
    chk("phase_rise_word", 32'(phase_rise_word), 1728);
    chk("res_mem_0", 32'(res_mem[0]), 32'hA000);
    chk("res_mem_1199", 32'(res_mem[1199]), 32'hA4AF);

    // Random tx_ready, rx_valid stuck high through SEND, stray start pulses.
    ready_mode = 1; rx_mode = 1;
    run_job(1'b1, "jobB");

    // Reset mid-job while reads stream every cycle.
    ready_mode = 0; rx_mode = 0;
    rx_sent = 0;
    pulse_start();
    begin
      int i;
      for (i = 0; i < 5000; i++) begin
        @(negedge clk); #1;
        if (exp_tx >= 500) break;
      end
      chk("reset_point_reached", 32'(exp_tx >= 500), 1);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Fresh jobs after the reset, back to back.
    ready_mode = 1; rx_mode = 0;
    run_job(1'b0, "jobC");
    run_job(1'b1, "jobD");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_stream_driver.md
CONV_STREAM_DRIVER -- requirements
Module: conv_stream_driver

Interface
REQ-001 Parameter N_IF, default 1728, ifmap words sent per job.
REQ-002 Parameter N_W, default 1296, weight words sent per job.
REQ-003 Parameter N_OF, default 1200, result words collected per job.
REQ-004 Parameter DW, default 16, data width; AW, default 12, address width.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  job request pulse, sampled in IDLE only.
REQ-008 busy  out  1  high in SEND or RECV.
REQ-009 done  out  1  one-cycle pulse at job end.
REQ-010 src_rd_en  out  1  source memory read strobe.
REQ-011 src_rd_addr  out  AW  source address; ifmap at 0..N_IF-1, weights at N_IF..N_IF+N_W-1.
REQ-012 src_rd_data  in  DW  read data, valid exactly 1 cycle after src_rd_en.
REQ-013 tx_valid / tx_ready / tx_data  out / in / out  1 / 1 / DW  stream to conv core din port.
REQ-014 tx_phase  out  1  0 while current tx word is ifmap, 1 while weight.
REQ-015 rx_valid / rx_ready / rx_data  in / out / in  1 / 1 / DW  stream from conv core dout port.
REQ-016 res_wr_en / res_wr_addr / res_wr_data  out / out / out  1 / AW / DW  result memory write port.

Function
REQ-017 FSM states IDLE, SEND, RECV, FIN; IDLE->SEND on start; SEND->RECV after N_IF+N_W tx handshakes; RECV->FIN after N_OF rx handshakes; FIN->IDLE unconditionally after one cycle.
REQ-018 start outside IDLE shall be ignored; start in FIN shall be ignored.
REQ-019 Handshake: word transfers on a cycle with valid and ready both high; tx_data/tx_phase stable while tx_valid high and tx_ready low.
REQ-020 tx_valid shall not drop without a handshake once asserted.
REQ-021 SEND uses a 2-entry output FIFO; a read issues only when FIFO occupancy plus in-flight reads < 2 and issued-read count < N_IF+N_W.
REQ-022 Read addresses issue strictly sequentially from 0; returned data enters FIFO the cycle after src_rd_en.
REQ-023 With tx_ready held high, tx throughput shall be one word per cycle after first-word latency of 2 cycles from start (start cycle N, src_rd_en at N+1, tx_valid at N+2).
REQ-024 tx_phase equals 1 exactly for the word with sequence index >= N_IF.
REQ-025 rx_ready shall be high only in RECV; it shall go low the cycle after the N_OF-th rx handshake.
REQ-026 Each rx handshake drives res_wr_en=1 same cycle (combinational), res_wr_data=rx_data, res_wr_addr=rx count 0..N_OF-1.
REQ-027 rx_valid during SEND is not accepted and produces no write.
REQ-028 Counters saturate-free: tx counter and rx counter reset to 0 on each IDLE->SEND transition; no wrap within a job.
REQ-029 done asserts only in FIN, for exactly one cycle; busy low in IDLE and FIN.
REQ-030 Simultaneous last tx handshake and rx_valid: rx word not accepted until next cycle (RECV).

Reset
REQ-031 rst high at any clock edge, including mid-job, returns FSM to IDLE, empties FIFO, clears counters and in-flight flag.
REQ-032 Outputs during/after reset: busy=0, done=0, src_rd_en=0, src_rd_addr=0, tx_valid=0, tx_data=0, tx_phase=0, rx_ready=0, res_wr_en=0, res_wr_addr=0, res_wr_data=0.
REQ-033 Read data returning the cycle after a reset shall be discarded.

Verification
REQ-034 Source memory word k = k; start, tx_ready=1 -> tx_data 0..3023 on consecutive cycles, tx_phase rises with word 1728, first tx_valid 2 cycles after start.
REQ-035 tx_ready random 50% -> identical ordered 3024-word sequence, no drop/duplicate, tx_data stable during stall, src_rd_en never exceeds FIFO capacity.
REQ-036 RECV with rx_data = 0xA000+n, rx_valid random -> result memory addr n holds 0xA000+n for n=0..1199, done pulses once, busy low next cycle.
REQ-037 rx_valid high throughout SEND -> zero res_wr_en pulses before RECV; first write addr 0.
REQ-038 rst asserted at tx word 500 with read in flight -> all outputs at reset values next cycle; new start restarts at src_rd_addr 0.
REQ-039 start pulsed during SEND and RECV -> no effect; exactly one done per job; back-to-back jobs give identical results.
